// File: rtl/multicycle_control_unit_if.sv
// Bus between the J17 multi-cycle sequencer and its instruction memory, ALU, regfile, data RAM and PC.
// The master modport is the sequencer; the slave modport is its surroundings.
interface multicycle_control_unit_if #(
    parameter int IW  = 32,
    parameter int OPW = 6,
    parameter int RW  = 5
);
    localparam int OW = IW - OPW - 1 - RW;

    // Handshakes: an instruction transfers on a rising edge where fetch_req && instr_valid;
    // a data store is offered by ramenable and completes on the edge where mem_ready is sampled 1.
    logic [IW-1:0]  instruction;
    logic           instr_valid;
    logic           fetch_req;
    logic [1:0]     flags;
    logic           alu_done;
    logic           mem_ready;
    logic [OPW-1:0] alucode;
    logic [RW-1:0]  op1;
    logic [OW-1:0]  op2;
    logic           imControl;
    logic           regenable;
    logic           ramenable;
    logic [2:0]     pcControl;
    logic [1:0]     stackSelect;
    logic           halted;
    logic           illegal;

    modport master (
        input  instruction, instr_valid, flags, alu_done, mem_ready,
        output fetch_req, alucode, op1, op2, imControl, regenable, ramenable,
               pcControl, stackSelect, halted, illegal
    );

    modport slave (
        output instruction, instr_valid, flags, alu_done, mem_ready,
        input  fetch_req, alucode, op1, op2, imControl, regenable, ramenable,
               pcControl, stackSelect, halted, illegal
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// J17 multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with HALT and illegal-opcode detection.
// Define J17_MULDIV_EN to make MUL/DIV/MULI/DIVI/MOD legal, waiting in EXECUTE for alu_done.
module multicycle_control_unit #(
    parameter int IW  = 32,
    parameter int OPW = 6,
    parameter int RW  = 5
) (
    input  logic                        clock,
    input  logic                        resetn,
    multicycle_control_unit_if.master   bus,
    output logic [2:0]                  o_dbg_state
);
    localparam int OW = IW - OPW - 1 - RW;

    localparam logic [OPW-1:0] OP_MUL  = OPW'(2);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(4);
    localparam logic [OPW-1:0] OP_MULI = OPW'(6);
    localparam logic [OPW-1:0] OP_DIVI = OPW'(7);
    localparam logic [OPW-1:0] OP_MOD  = OPW'(12);
    localparam logic [OPW-1:0] OP_SR   = OPW'(14);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(15);
    localparam logic [OPW-1:0] OP_JE   = OPW'(16);
    localparam logic [OPW-1:0] OP_JB   = OPW'(17);
    localparam logic [OPW-1:0] OP_JA   = OPW'(18);
    localparam logic [OPW-1:0] OP_JNE  = OPW'(19);
    localparam logic [OPW-1:0] OP_JBE  = OPW'(20);
    localparam logic [OPW-1:0] OP_JAE  = OPW'(21);
    localparam logic [OPW-1:0] OP_JZ   = OPW'(22);
    localparam logic [OPW-1:0] OP_JNZ  = OPW'(23);
    localparam logic [OPW-1:0] OP_MOV  = OPW'(24);
    localparam logic [OPW-1:0] OP_HLT  = OPW'(26);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [IW-1:0]  r_ir;
    logic [OPW-1:0] r_alucode;
    logic           r_imctl;
    logic           r_illegal;
    logic           r_taken;
    logic           r_wb_reg;

    // Fields of the incoming word, used to register the ALU controls as the IR is loaded.
    logic [OPW-1:0] w_in_opcode;
    logic           w_in_immform;
    assign w_in_opcode  = bus.instruction[IW-1 -: OPW];
    assign w_in_immform = (w_in_opcode >= OP_ADDI) && (w_in_opcode <= OP_DIVI);

    logic [OPW-1:0] w_opcode;
    logic           w_imm;
    logic           w_carry;
    logic           w_zero;
    logic           w_is_alu;
    logic           w_is_jump;
    logic           w_is_mov;
    logic           w_is_hlt;
    logic           w_is_muldiv;
    logic           w_illegal_op;
    logic           w_cond;

    assign w_opcode    = r_ir[IW-1 -: OPW];
    assign w_imm       = r_ir[IW-OPW-1];
    assign w_carry     = bus.flags[1];
    assign w_zero      = bus.flags[0];
    assign w_is_alu    = (w_opcode <= OP_SR);
    assign w_is_jump   = (w_opcode >= OP_JMP) && (w_opcode <= OP_JNZ);
    assign w_is_mov    = (w_opcode == OP_MOV);
    assign w_is_hlt    = (w_opcode == OP_HLT);
    assign w_is_muldiv = (w_opcode == OP_MUL)  || (w_opcode == OP_DIV) ||
                         (w_opcode == OP_MULI) || (w_opcode == OP_DIVI) ||
                         (w_opcode == OP_MOD);

`ifdef J17_MULDIV_EN
    assign w_illegal_op = (w_opcode > OP_HLT);
`else
    assign w_illegal_op = (w_opcode > OP_HLT) || w_is_muldiv;
    logic w_unused_alu_done;
    assign w_unused_alu_done = bus.alu_done;
`endif

    always_comb begin
        w_cond = 1'b0;
        case (w_opcode)
            OP_JMP:        w_cond = 1'b1;
            OP_JE, OP_JZ:  w_cond = w_zero;
            OP_JNE, OP_JNZ: w_cond = !w_zero;
            OP_JB:         w_cond = w_carry;
            OP_JAE:        w_cond = !w_carry;
            OP_JA:         w_cond = !w_carry && !w_zero;
            OP_JBE:        w_cond = w_carry || w_zero;
            default:       w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:     if (bus.instr_valid) w_next_state = S_DECODE;
            S_DECODE:    w_next_state = S_EXECUTE;
            S_EXECUTE: begin
                if (w_illegal_op)            w_next_state = S_WRITEBACK;
                else if (w_is_hlt)           w_next_state = S_HALT;
                else if (w_is_mov && w_imm)  w_next_state = S_MEMORY;
`ifdef J17_MULDIV_EN
                else if (w_is_muldiv && !bus.alu_done) w_next_state = S_EXECUTE;
`endif
                else                         w_next_state = S_WRITEBACK;
            end
            S_MEMORY:    if (bus.mem_ready) w_next_state = S_WRITEBACK;
            S_WRITEBACK: w_next_state = S_FETCH;
            S_HALT:      w_next_state = S_HALT;
            default:     w_next_state = S_FETCH;
        endcase
    end

    // Jump and writeback decisions are taken in EXECUTE, where the ALU flags are valid.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_ir      <= '0;
            r_alucode <= '0;
            r_imctl   <= 1'b0;
            r_illegal <= 1'b0;
            r_taken   <= 1'b0;
            r_wb_reg  <= 1'b0;
        end else begin
            if (r_state == S_FETCH && bus.instr_valid) begin
                r_ir      <= bus.instruction;
                r_alucode <= w_in_immform ? (w_in_opcode - OP_ADDI) : w_in_opcode;
                r_imctl   <= w_in_immform || bus.instruction[IW-OPW-1];
            end
            if (r_state == S_DECODE && w_illegal_op) begin
                r_illegal <= 1'b1;
            end
            if (r_state == S_EXECUTE) begin
                r_taken  <= !w_illegal_op && w_is_jump && w_cond;
                r_wb_reg <= !w_illegal_op && (w_is_alu || (w_is_mov && !w_imm));
            end
        end
    end

    always_comb begin
        bus.fetch_req   = (r_state == S_FETCH);
        bus.regenable   = (r_state == S_WRITEBACK) && r_wb_reg;
        bus.ramenable   = (r_state == S_MEMORY);
        bus.halted      = (r_state == S_HALT);
        bus.pcControl   = 3'd2;
        if (r_state == S_WRITEBACK) begin
            bus.pcControl = r_taken ? 3'd1 : 3'd0;
        end
        bus.alucode     = r_alucode;
        bus.imControl   = r_imctl;
        bus.op1         = r_ir[IW-OPW-2 -: RW];
        bus.op2         = r_ir[OW-1:0];
        bus.stackSelect = 2'd0;
        bus.illegal     = r_illegal;
        o_dbg_state     = r_state;
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised scoreboard bench for multicycle_control_unit; builds with or without J17_MULDIV_EN.
module tb_multicycle_control_unit;
    localparam int W = 55;
`ifdef J17_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic       clock;
    logic       resetn;
    logic [2:0] dbg_state;

    multicycle_control_unit_if #(.IW(32), .OPW(6), .RW(5)) bus ();

    multicycle_control_unit #(.IW(32), .OPW(6), .RW(5)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    bit model_illegal = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.instruction = '0;
        bus.instr_valid = 1'b0;
        bus.flags = 2'b00;
        bus.alu_done = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        model_illegal = 1'b0;
    endtask

    task automatic check_reset_state();
        check("rst_fetch_req", bus.fetch_req, 1);
        check("rst_pcControl", bus.pcControl, 2);
        check("rst_halted", bus.halted, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_regenable", bus.regenable, 0);
        check("rst_ramenable", bus.ramenable, 0);
        check("rst_imControl", bus.imControl, 0);
        check("rst_alucode", bus.alucode, 0);
        check("rst_stackSelect", bus.stackSelect, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.fetch_req) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!ok) check("fetch_req_timeout", 0, 1);
    endtask

    task automatic wait_ramenable(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.ramenable) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!ok) check("ramenable_timeout", 0, 1);
    endtask

    // Reference model: the expected observable result of one instruction, from the opcode table.
    task automatic issue(input int opc, input bit imm, input int o1, input int o2,
                         input logic [1:0] fl, input int fw, input int mw, input int aw);
        bit ok, muldiv, ill, alu, store, taken, halt_i, regen, im_exp;
        bit c, z;
        int pc, ram, lat, alu_exp;
        logic [5:0]  opc6;
        logic [4:0]  o1_5;
        logic [19:0] o2_20;
        opc6 = opc[5:0];
        o1_5 = o1[4:0];
        o2_20 = o2[19:0];
        c = fl[1];
        z = fl[0];
        muldiv = (opc == 2) || (opc == 3) || (opc == 6) || (opc == 7) || (opc == 12);
        ill = (opc > 26) || (muldiv && !MULDIV);
        model_illegal = model_illegal || ill;
        alu = !ill && (opc <= 14);
        store = !ill && (opc == 24) && imm;
        halt_i = (opc == 26);
        regen = alu || (!ill && opc == 24 && !imm);
        case (opc)
            15: taken = 1'b1;
            16, 22: taken = z;
            19, 23: taken = !z;
            17: taken = c;
            21: taken = !c;
            18: taken = !c && !z;
            20: taken = c || z;
            default: taken = 1'b0;
        endcase
        pc = halt_i ? 2 : (taken ? 1 : 0);
        ram = store ? mw + 1 : 0;
        lat = 3 + ((muldiv && !ill) ? aw : 0) + ram;
        alu_exp = (opc >= 4 && opc <= 7) ? opc - 4 : opc;
        im_exp = (opc >= 4 && opc <= 7) ? 1'b1 : imm;

        wait_fetch(ok);
        if (!ok) return;
        exp_q.push_back({halt_i, regen, pc[2:0], alu, alu_exp[5:0], im_exp, o1_5, o2_20,
                         model_illegal, ram[7:0], lat[7:0]});
        bus.instruction = {opc6, imm, o1_5, o2_20};
        bus.flags = fl;
        bus.alu_done = (muldiv && MULDIV) ? 1'b0 : 1'($urandom_range(0, 1));
        repeat (fw) begin
            @(posedge clock);
            #1;
        end
        bus.instr_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.instr_valid = 1'b0;
        bus.instruction = $urandom;
        if (muldiv && MULDIV) begin
            @(posedge clock);
            #1;
            repeat (aw) begin
                @(posedge clock);
                #1;
            end
            bus.alu_done = 1'b1;
            @(posedge clock);
            #1;
            bus.alu_done = 1'b0;
        end
        if (store) begin
            wait_ramenable(ok);
            if (!ok) return;
            repeat (mw) begin
                @(posedge clock);
                #1;
            end
            bus.mem_ready = 1'b1;
            @(posedge clock);
            #1;
            bus.mem_ready = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int cyc = 0;
    int ram_cnt = 0;
    bit seen_halt = 1'b0;

    always @(negedge clock) begin
        logic [W-1:0] e;
        logic e_halt, e_regen, e_chk, e_im, e_ill;
        logic [2:0] e_pc;
        logic [5:0] e_alu;
        logic [4:0] e_op1;
        logic [19:0] e_op2;
        logic [7:0] e_ram, e_lat;
        if (!resetn) begin
            cyc = 0;
            ram_cnt = 0;
            seen_halt = 1'b0;
        end else begin
            if (bus.fetch_req && bus.instr_valid) cyc = 0;
            else cyc++;
            if (bus.ramenable) ram_cnt++;
            if (bus.regenable || bus.ramenable) begin
                check("strobe_overlap", int'(bus.regenable && bus.ramenable), 0);
                check("regen_outside_wb", int'(bus.regenable && bus.pcControl == 3'd2), 0);
            end
            if (bus.pcControl != 3'd2 || (bus.halted && !seen_halt)) begin
                if (bus.halted) seen_halt = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    {e_halt, e_regen, e_pc, e_chk, e_alu, e_im, e_op1, e_op2, e_ill, e_ram, e_lat} = e;
                    check("halted", bus.halted, e_halt);
                    check("regenable", bus.regenable, e_regen);
                    check("pcControl", bus.pcControl, e_pc);
                    if (e_chk) begin
                        check("alucode", bus.alucode, e_alu);
                        check("imControl", bus.imControl, e_im);
                    end
                    check("op1", bus.op1, e_op1);
                    check("op2", bus.op2, e_op2);
                    check("illegal", bus.illegal, e_ill);
                    check("ram_cycles", ram_cnt, e_ram);
                    check("latency", cyc, e_lat);
                end
                ram_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int bad;
        do_reset();
        check_reset_state();

        issue(4, 1'b0, 3, 5, 2'b00, 0, 0, 0);
        issue(16, 1'b0, 1, 20'h1234, 2'b01, 1, 0, 0);
        issue(16, 1'b0, 1, 20'h1234, 2'b00, 0, 0, 0);
        for (int f = 0; f < 4; f++) issue(18, 1'b0, 2, 100 + f, f[1:0], 0, 0, 0);
        for (int f = 0; f < 4; f++) issue(20, 1'b0, 2, 200 + f, f[1:0], 0, 0, 0);
        issue(24, 1'b1, 7, 20'h0abc, 2'b00, 0, 3, 0);
        issue(24, 1'b0, 9, 4, 2'b00, 2, 0, 0);
        issue(0, 1'b1, 4, 6, 2'b10, 0, 0, 0);
        issue(40, 1'b0, 1, 1, 2'b00, 0, 0, 0);
        issue(2, 1'b0, 1, 2, 2'b00, 0, 0, 5);
        issue(26, 1'b0, 0, 0, 2'b00, 0, 0, 0);
        drain();

        bad = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (bus.fetch_req || !bus.halted) bad++;
        end
        check("halt_hold_cycles_bad", bad, 0);

        do_reset();
        check_reset_state();

        // Abort a store in MEMORY with reset: the strobe must drop immediately.
        wait_fetch(ok);
        if (ok) begin
            bus.instruction = {6'd24, 1'b1, 5'd3, 20'd77};
            bus.instr_valid = 1'b1;
            @(posedge clock);
            #1;
            bus.instr_valid = 1'b0;
            wait_ramenable(ok);
            repeat (2) begin
                @(posedge clock);
                #1;
            end
            resetn = 1'b0;
            @(posedge clock);
            #1;
            check("rst_mem_ramenable", bus.ramenable, 0);
            check("rst_mem_fetch_req", bus.fetch_req, 1);
            check("rst_mem_regenable", bus.regenable, 0);
            resetn = 1'b1;
            model_illegal = 1'b0;
        end

        for (int n = 0; n < 150; n++) begin
            int opc;
            if ($urandom_range(0, 9) == 0) opc = $urandom_range(27, 63);
            else opc = $urandom_range(0, 25);
            issue(opc, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 20'hfffff),
                  2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 4),
                  $urandom_range(0, 6));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
